// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the control sequencer: FSM states, opcode
// constants, instruction-word field positions and the opcode classifier.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_RST,
    ST_T0,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_T4,
    ST_T5,
    ST_T6,
    ST_HALT
  } state_t;

  // Execution shape of an instruction once it has been fetched
  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_ALU,
    CLS_MULDIV,
    CLS_UNARY,
    CLS_HALT
  } op_class_t;

  localparam logic [4:0] OPC_ADD      = 5'b00011;
  localparam logic [4:0] OPC_ALU_LAST = 5'b01101;
  localparam logic [4:0] OPC_MUL      = 5'b01110;
  localparam logic [4:0] OPC_DIV      = 5'b01111;
  localparam logic [4:0] OPC_NOT      = 5'b10000;
  localparam logic [4:0] OPC_NEG      = 5'b10001;
  localparam logic [4:0] OPC_NOP      = 5'b11010;
  localparam logic [4:0] OPC_HALT     = 5'b11011;

  localparam int IR_OPC_HI = 31;
  localparam int IR_OPC_LO = 27;
  localparam int IR_RA_HI  = 26;
  localparam int IR_RA_LO  = 23;
  localparam int IR_RB_HI  = 22;
  localparam int IR_RB_LO  = 19;
  localparam int IR_RC_HI  = 18;
  localparam int IR_RC_LO  = 15;

  // Opcodes outside every known group retire like a NOP
  function automatic op_class_t classify(input logic [4:0] opc);
    op_class_t cls;
    if (opc >= OPC_ADD && opc <= OPC_ALU_LAST)    cls = CLS_ALU;
    else if (opc == OPC_MUL || opc == OPC_DIV)    cls = CLS_MULDIV;
    else if (opc == OPC_NOT || opc == OPC_NEG)    cls = CLS_UNARY;
    else if (opc == OPC_HALT)                     cls = CLS_HALT;
    else if (opc == OPC_NOP)                      cls = CLS_NOP;
    else                                          cls = CLS_NOP;
    return cls;
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Bundle between the control sequencer and the datapath: instruction and
// memory/halt inputs toward the sequencer, control strobes back out.
interface control_sequencer_if;

  logic [31:0]           ir;
  logic                  mem_ready;
  logic                  stop;

  logic                  pc_out;
  logic                  mar_in;
  logic                  inc_pc;
  logic                  pc_in;
  logic                  read;
  logic                  mdr_in;
  logic                  mdr_out;
  logic                  ir_in;
  logic                  y_in;
  logic                  z_in;
  logic                  zlo_out;
  logic                  zhi_out;
  logic                  lo_in;
  logic                  hi_in;
  logic [4:0]            alu_opcode;
  logic [15:0]           r_in;
  logic [15:0]           r_out;
  logic                  run;
  cpu_ctrl_pkg::state_t  state;

  modport master (
    input  ir, mem_ready, stop,
    output pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in,
           y_in, z_in, zlo_out, zhi_out, lo_in, hi_in, alu_opcode,
           r_in, r_out, run, state
  );

  modport slave (
    output ir, mem_ready, stop,
    input  pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in,
           y_in, z_in, zlo_out, zhi_out, lo_in, hi_in, alu_opcode,
           r_in, r_out, run, state
  );

endinterface

// File: rtl/reg_select_decode.sv
// Turns a 4-bit register number plus enable into a one-hot register strobe.
module reg_select_decode (
  input  logic [3:0]  sel,
  input  logic        en,
  output logic [15:0] onehot
);

  // At most one bit set, none when disabled
  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control sequencer: fetch (T0-T2) then a class-dependent execute
// sequence (T3-T6). Strobes decode from the current state and ir.
module control_sequencer
  import cpu_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                clr,
  control_sequencer_if.master bus
);

  state_t     state;
  state_t     boundary_state;
  logic       stop_pend;
  op_class_t  cls;
  logic [4:0] opcode;
  logic [3:0] ra;
  logic [3:0] rb;
  logic [3:0] rc;
  logic       r_in_en;
  logic       r_out_en;
  logic [3:0] r_in_sel;
  logic [3:0] r_out_sel;
  logic       unused_ir_bits;

  assign opcode         = bus.ir[IR_OPC_HI:IR_OPC_LO];
  assign ra             = bus.ir[IR_RA_HI:IR_RA_LO];
  assign rb             = bus.ir[IR_RB_HI:IR_RB_LO];
  assign rc             = bus.ir[IR_RC_HI:IR_RC_LO];
  assign unused_ir_bits = ^bus.ir[IR_RC_LO-1:0];
  assign cls            = classify(opcode);

  // A halt request seen at any point of an instruction takes effect only
  // when the instruction completes.
  assign boundary_state = (bus.stop || stop_pend) ? ST_HALT : ST_T0;

  // State register plus pending-halt flag; clr clears both immediately
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= ST_RST;
      stop_pend <= 1'b0;
    end else begin
      if (bus.stop && state != ST_RST && state != ST_HALT)
        stop_pend <= 1'b1;
      case (state)
        ST_RST:  state <= boundary_state;
        ST_T0:   state <= ST_T1;
        ST_T1:   if (bus.mem_ready) state <= ST_T2;
        ST_T2: begin
          case (cls)
            CLS_ALU, CLS_MULDIV, CLS_UNARY: state <= ST_T3;
            CLS_HALT:                       state <= ST_HALT;
            default:                        state <= boundary_state;
          endcase
        end
        ST_T3:   state <= ST_T4;
        ST_T4:   state <= (cls == CLS_UNARY) ? boundary_state : ST_T5;
        ST_T5:   state <= (cls == CLS_MULDIV) ? ST_T6 : boundary_state;
        ST_T6:   state <= boundary_state;
        ST_HALT: state <= ST_HALT;
        default: state <= ST_RST;
      endcase
    end
  end

  // Strobe decode; ir only influences T3-T6, pc_in marks the T1 exit cycle
  always_comb begin
    bus.pc_out     = 1'b0;
    bus.mar_in     = 1'b0;
    bus.inc_pc     = 1'b0;
    bus.pc_in      = 1'b0;
    bus.read       = 1'b0;
    bus.mdr_in     = 1'b0;
    bus.mdr_out    = 1'b0;
    bus.ir_in      = 1'b0;
    bus.y_in       = 1'b0;
    bus.z_in       = 1'b0;
    bus.zlo_out    = 1'b0;
    bus.zhi_out    = 1'b0;
    bus.lo_in      = 1'b0;
    bus.hi_in      = 1'b0;
    bus.alu_opcode = 5'b00000;
    r_in_en        = 1'b0;
    r_out_en       = 1'b0;
    r_in_sel       = ra;
    r_out_sel      = rb;
    case (state)
      ST_T0: begin
        bus.pc_out     = 1'b1;
        bus.mar_in     = 1'b1;
        bus.inc_pc     = 1'b1;
        bus.z_in       = 1'b1;
        bus.alu_opcode = OPC_ADD;
      end
      ST_T1: begin
        bus.zlo_out = 1'b1;
        bus.read    = 1'b1;
        bus.mdr_in  = 1'b1;
        bus.pc_in   = bus.mem_ready;
      end
      ST_T2: begin
        bus.mdr_out = 1'b1;
        bus.ir_in   = 1'b1;
      end
      ST_T3: begin
        if (cls == CLS_ALU || cls == CLS_MULDIV) begin
          r_out_en = 1'b1;
          bus.y_in = 1'b1;
        end else if (cls == CLS_UNARY) begin
          r_out_en       = 1'b1;
          bus.z_in       = 1'b1;
          bus.alu_opcode = opcode;
        end
      end
      ST_T4: begin
        if (cls == CLS_ALU || cls == CLS_MULDIV) begin
          r_out_en       = 1'b1;
          r_out_sel      = rc;
          bus.z_in       = 1'b1;
          bus.alu_opcode = opcode;
        end else if (cls == CLS_UNARY) begin
          bus.zlo_out = 1'b1;
          r_in_en     = 1'b1;
        end
      end
      ST_T5: begin
        if (cls == CLS_ALU) begin
          bus.zlo_out = 1'b1;
          r_in_en     = 1'b1;
        end else if (cls == CLS_MULDIV) begin
          bus.zlo_out = 1'b1;
          bus.lo_in   = 1'b1;
        end
      end
      ST_T6: begin
        bus.zhi_out = 1'b1;
        bus.hi_in   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.run   = (state != ST_RST) && (state != ST_HALT);
  assign bus.state = state;

  reg_select_decode u_r_in_dec (
    .sel    (r_in_sel),
    .en     (r_in_en),
    .onehot (bus.r_in)
  );

  reg_select_decode u_r_out_dec (
    .sel    (r_out_sel),
    .en     (r_out_en),
    .onehot (bus.r_out)
  );

endmodule
